// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS data bits (LSB first), optional even/odd parity,
// 1 or 2 stop bits, start-bit glitch rejection and a valid/ready holding register with overrun flag.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_Serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_ZERO      = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_ZERO      = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE       = IW'(1);
    localparam logic [IW-1:0] IDX_LAST      = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST     = 1'(STOP_BITS - 1);
    localparam logic          ODD_PAR       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    logic                 sync1_q;
    logic                 rxs_q;
    state_e               state_q,    state_d;
    logic [CW-1:0]        cnt_q,      cnt_d;
    logic [IW-1:0]        idx_q,      idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 perr_q,     perr_d;
    logic                 ferr_q,     ferr_d;
    logic                 done_q,     done_d;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;

    // Two-flop synchroniser for the asynchronous serial line, idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx_Serial;
            rxs_q   <= sync1_q;
        end
    end

    // Receiver FSM state and frame assembly registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_ZERO;
            idx_q      <= IDX_ZERO;
            stop_idx_q <= 1'b0;
            shift_q    <= {DATA_BITS{1'b0}};
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; error flags are sampled on the cycle they become final
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = CNT_ZERO;
                if (!rxs_q) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = IDX_ZERO;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d          = CNT_ZERO;
                    shift_d[idx_q] = rxs_q;
                    if (idx_q == IDX_LAST) begin
                        idx_d      = IDX_ZERO;
                        stop_idx_d = 1'b0;
                        state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    perr_d  = ((^shift_q) ^ rxs_q) != ODD_PAR;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d  = CNT_ZERO;
                    ferr_d = ferr_q | ~rxs_q;
                    // Leave straight away so a back-to-back start edge is not missed
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_idx_d = ~stop_idx_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Holding register: load a finished frame if free or draining this cycle, else flag overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q    <= {DATA_BITS{1'b0}};
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            busy_q    <= (state_d != S_IDLE);
            if (done_q) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q    <= shift_q;
                    parity_err_q <= perr_q;
                    frame_err_q  <= ferr_q;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end else begin
                rx_valid_q <= rx_valid_q;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 8E1, 7N2) share one clock;
// stimulus pushes expected words, a negedge monitor pops them on every rx_valid & rx_ready.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, bz0, bz1, bz2;

    int n_checks = 0;
    int n_errors = 0;
    int ovr_cnt[3] = '{0, 0, 0};
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] q2[$];

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .rx_Serial(rx0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(bz0));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rx_Serial(rx1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(bz1));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .rx_Serial(rx2), .rx_data(d2), .rx_valid(v2), .rx_ready(rdy2),
        .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .busy(bz2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input int inst, input logic [8:0] d, input logic pe, input logic fe);
        case (inst)
            0: q0.push_back({pe, fe, d});
            1: q1.push_back({pe, fe, d});
            default: q2.push_back({pe, fe, d});
        endcase
    endtask

    task automatic sb_pop(input int inst, input logic [8:0] d, input logic pe, input logic fe);
        logic [10:0] e;
        logic have;
        have = 1'b1;
        e = 11'h000;
        case (inst)
            0: if (q0.size() == 0) have = 1'b0; else e = q0.pop_front();
            1: if (q1.size() == 0) have = 1'b0; else e = q1.pop_front();
            default: if (q2.size() == 0) have = 1'b0; else e = q2.pop_front();
        endcase
        n_checks++;
        if (!have) begin
            n_errors++;
            $display("FAIL sb_u%0d unexpected word: got pe=%0b fe=%0b data=%0h", inst, pe, fe, d);
        end else if ({pe, fe, d} !== e) begin
            n_errors++;
            $display("FAIL sb_u%0d: got pe=%0b fe=%0b data=%0h expected pe=%0b fe=%0b data=%0h",
                     inst, pe, fe, d, e[10], e[9], e[8:0]);
        end
    endtask

    // Monitor: one scoreboard pop per accepted word, overrun pulses counted per cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (v0 && rdy0) sb_pop(0, {1'b0, d0}, pe0, fe0);
            if (v1 && rdy1) sb_pop(1, {1'b0, d1}, pe1, fe1);
            if (v2 && rdy2) sb_pop(2, {2'b00, d2}, pe2, fe2);
            if (ov0) ovr_cnt[0]++;
            if (ov1) ovr_cnt[1]++;
            if (ov2) ovr_cnt[2]++;
        end
    end

    task automatic setline(input int inst, input logic v);
        case (inst)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int inst, input logic v);
        setline(inst, v);
        idle(CPB);
    endtask

    // pbit < 0 means no parity bit on the wire
    task automatic send(input int inst, input logic [8:0] data, input int nbits,
                        input int pbit, input int nstop, input logic stop_v);
        drive(inst, 1'b0);
        for (int i = 0; i < nbits; i++) drive(inst, data[i]);
        if (pbit >= 0) drive(inst, pbit[0]);
        for (int i = 0; i < nstop; i++) drive(inst, stop_v);
        setline(inst, 1'b1);
    endtask

    task automatic wait_drain(input int inst);
        int sz;
        sz = 1;
        for (int i = 0; i < 200 && sz != 0; i++) begin
            case (inst)
                0: sz = q0.size();
                1: sz = q1.size();
                default: sz = q2.size();
            endcase
            if (sz != 0) @(negedge clk);
        end
        check($sformatf("drain_u%0d", inst), sz, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", d0, 0);
        check("rst_valid", v0, 0);
        check("rst_perr", pe0, 0);
        check("rst_ferr", fe0, 0);
        check("rst_ovr", ov0, 0);
        check("rst_busy", bz0, 0);
        rst_n = 1'b1;
        idle(4);

        // 8N1 basic word
        exp_push(0, 9'h0A5, 1'b0, 1'b0);
        send(0, 9'h0A5, 8, -1, 1, 1'b1);
        check("busy_after_stop", bz0, 0);
        wait_drain(0);

        // Start-bit glitch shorter than half a bit
        setline(0, 1'b0);
        idle(5);
        check("glitch_busy_rise", bz0, 1);
        setline(0, 1'b1);
        idle(20);
        check("glitch_busy_fall", bz0, 0);
        check("glitch_no_valid", v0, 0);

        // Stop bit low, then a clean frame
        exp_push(0, 9'h03C, 1'b0, 1'b1);
        send(0, 9'h03C, 8, -1, 1, 1'b0);
        idle(2 * CPB);
        exp_push(0, 9'h0C3, 1'b0, 1'b0);
        send(0, 9'h0C3, 8, -1, 1, 1'b1);
        wait_drain(0);

        // Overrun: second frame dropped while the first waits
        rdy0 = 1'b0;
        exp_push(0, 9'h011, 1'b0, 1'b0);
        send(0, 9'h011, 8, -1, 1, 1'b1);
        send(0, 9'h022, 8, -1, 1, 1'b1);
        idle(4);
        check("ovr_pulses", ovr_cnt[0], 1);
        check("ovr_hold_data", d0, 8'h11);
        check("ovr_hold_valid", v0, 1);
        @(posedge clk);
        #1 rdy0 = 1'b1;
        idle(2);
        check("ovr_drained_valid", v0, 0);
        wait_drain(0);

        // Reset in the middle of data bit 4
        drive(0, 1'b0);
        for (int i = 0; i < 4; i++) drive(0, 1'b1);
        setline(0, 1'b0);
        idle(5);
        rst_n = 1'b0;
        #1;
        check("midrst_data", d0, 0);
        check("midrst_busy", bz0, 0);
        check("midrst_valid", v0, 0);
        setline(0, 1'b1);
        idle(3);
        rst_n = 1'b1;
        idle(4);
        exp_push(0, 9'h096, 1'b0, 1'b0);
        send(0, 9'h096, 8, -1, 1, 1'b1);
        wait_drain(0);

        // Even parity: wrong parity bit, then correct one
        exp_push(1, 9'h05A, 1'b1, 1'b0);
        send(1, 9'h05A, 8, 1, 1, 1'b1);
        idle(CPB);
        exp_push(1, 9'h05A, 1'b0, 1'b0);
        send(1, 9'h05A, 8, 0, 1, 1'b1);
        wait_drain(1);

        // 7N2 back-to-back frames
        exp_push(2, 9'h07F, 1'b0, 1'b0);
        exp_push(2, 9'h001, 1'b0, 1'b0);
        send(2, 9'h07F, 7, -1, 2, 1'b1);
        send(2, 9'h001, 7, -1, 2, 1'b1);
        wait_drain(2);

        idle(4);
        check("ovr_total_u0", ovr_cnt[0], 1);
        check("ovr_total_u1", ovr_cnt[1], 0);
        check("ovr_total_u2", ovr_cnt[2], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
